// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared types for the multiport register file
package regfile_mp_pkg;
  typedef enum logic {ST_INIT, ST_RUN} state_e;
endpackage

// File: rtl/regfile_sb.sv
// regfile_sb: per-register busy scoreboard with claim, clear and sweep-clear
module regfile_sb #(
  parameter int REG_COUNT = 16,
  localparam int ID_LEN = $clog2(REG_COUNT)
) (
  input  logic                 clk_i,
  input  logic                 sweep_en_i,
  input  logic [ID_LEN-1:0]    sweep_id_i,
  input  logic                 clr_en_i,
  input  logic [ID_LEN-1:0]    clr_id_i,
  input  logic                 claim_en_i,
  input  logic [ID_LEN-1:0]    claim_id_i,
  output logic [REG_COUNT-1:0] busy_nxt_o
);
  logic [REG_COUNT-1:0] busy_q;
  // next busy state; a claim overrides a same-cycle clear of the same index
  always_comb begin
    busy_nxt_o = busy_q;
    for (int i = 0; i < REG_COUNT; i++)
      busy_nxt_o[i] = (claim_en_i && claim_id_i == ID_LEN'(i)) ? 1'b1 :
                      ((clr_en_i && clr_id_i == ID_LEN'(i)) ||
                       (sweep_en_i && sweep_id_i == ID_LEN'(i))) ? 1'b0 : busy_q[i];
  end
  // no reset: the init sweep clears every bit
  always_ff @(posedge clk_i) busy_q <= busy_nxt_o;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: 2-read/1-write register file with busy scoreboard and init sweep
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int                  WORD_LEN       = 64,
  parameter int                  REG_COUNT      = 16,
  parameter logic [WORD_LEN-1:0] GP_RESET_VALUE = 64'hAAAAAAAAAAAAAAAA,
  localparam int                 ID_LEN         = $clog2(REG_COUNT)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  output logic                ready_o,
  input  logic [ID_LEN-1:0]   rd_a_id_i,
  output logic [WORD_LEN-1:0] rd_a_value_o,
  output logic                rd_a_busy_o,
  input  logic [ID_LEN-1:0]   rd_b_id_i,
  output logic [WORD_LEN-1:0] rd_b_value_o,
  output logic                rd_b_busy_o,
  input  logic                wr_en_i,
  input  logic [ID_LEN-1:0]   wr_id_i,
  input  logic [WORD_LEN-1:0] wr_value_i,
  input  logic                claim_en_i,
  input  logic [ID_LEN-1:0]   claim_id_i
);
  typedef logic [ID_LEN-1:0] id_t;
  state_e              state;
  id_t                 cnt;
  logic [WORD_LEN-1:0] mem [REG_COUNT];
  logic                init_act, run_act, mem_we;
  id_t                 mem_wa;
  logic [WORD_LEN-1:0] mem_wd;
  logic [REG_COUNT-1:0] busy_nxt;
  assign init_act = !reset_i && state == ST_INIT;
  assign run_act  = !reset_i && state == ST_RUN;
  // single write port shared between the init sweep and normal writes
  always_comb begin
    mem_we = init_act || (run_act && wr_en_i);
    mem_wa = init_act ? cnt : wr_id_i;
    mem_wd = init_act ? GP_RESET_VALUE : wr_value_i;
  end
  // init sweep walks every index once, then enters RUN for good
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= ST_INIT;
      cnt     <= '0;
      ready_o <= 1'b0;
    end else if (state == ST_INIT) begin
      cnt <= cnt + id_t'(1);
      if (cnt == id_t'(REG_COUNT - 1)) begin
        state   <= ST_RUN;
        ready_o <= 1'b1;
      end
    end
  end
  // storage without reset so it maps onto distributed RAM
  always_ff @(posedge clk_i) if (mem_we) mem[mem_wa] <= mem_wd;
  regfile_sb #(.REG_COUNT(REG_COUNT)) u_sb (
    .clk_i      (clk_i),
    .sweep_en_i (init_act),
    .sweep_id_i (cnt),
    .clr_en_i   (run_act && wr_en_i),
    .clr_id_i   (wr_id_i),
    .claim_en_i (run_act && claim_en_i),
    .claim_id_i (claim_id_i),
    .busy_nxt_o (busy_nxt)
  );
  // registered reads with same-cycle write/claim bypass, zero until running
  always_ff @(posedge clk_i) begin
    if (!run_act) begin
      rd_a_value_o <= '0;
      rd_a_busy_o  <= 1'b0;
      rd_b_value_o <= '0;
      rd_b_busy_o  <= 1'b0;
    end else begin
      rd_a_value_o <= (wr_en_i && wr_id_i == rd_a_id_i) ? wr_value_i : mem[rd_a_id_i];
      rd_a_busy_o  <= busy_nxt[rd_a_id_i];
      rd_b_value_o <= (wr_en_i && wr_id_i == rd_b_id_i) ? wr_value_i : mem[rd_b_id_i];
      rd_b_busy_o  <= busy_nxt[rd_b_id_i];
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp
module tb_regfile_mp;
  localparam logic [63:0] RV = 64'hAAAAAAAAAAAAAAAA;
  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        ready_o;
  logic [3:0]  rd_a_id_i = '0, rd_b_id_i = '0, wr_id_i = '0, claim_id_i = '0;
  logic [63:0] rd_a_value_o, rd_b_value_o, wr_value_i = '0;
  logic        rd_a_busy_o, rd_b_busy_o, wr_en_i = 1'b0, claim_en_i = 1'b0;
  int vecs = 0, miscompares = 0;

  regfile_mp dut (
    .clk_i(clk_i), .reset_i(reset_i), .ready_o(ready_o),
    .rd_a_id_i(rd_a_id_i), .rd_a_value_o(rd_a_value_o), .rd_a_busy_o(rd_a_busy_o),
    .rd_b_id_i(rd_b_id_i), .rd_b_value_o(rd_b_value_o), .rd_b_busy_o(rd_b_busy_o),
    .wr_en_i(wr_en_i), .wr_id_i(wr_id_i), .wr_value_i(wr_value_i),
    .claim_en_i(claim_en_i), .claim_id_i(claim_id_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sweep(input string tag);
    for (int c = 0; c < 16; c++) begin
      chk({tag, "_ready_low"}, 64'(ready_o), 64'd0);
      step();
    end
    chk({tag, "_ready_high"}, 64'(ready_o), 64'd1);
  endtask

  initial begin
    step(); step(); step();
    chk("rst_ready", 64'(ready_o), 64'd0);
    chk("rst_rd_a", rd_a_value_o, 64'd0);
    chk("rst_rd_b_busy", 64'(rd_b_busy_o), 64'd0);
    reset_i = 1'b0;
    sweep("init");
    for (int i = 0; i < 16; i++) begin
      rd_a_id_i = 4'(i);
      rd_b_id_i = 4'(15 - i);
      step();
      chk("init_rd_a", rd_a_value_o, RV);
      chk("init_rd_b", rd_b_value_o, RV);
      chk("init_busy_a", 64'(rd_a_busy_o), 64'd0);
    end
    wr_en_i = 1; wr_id_i = 3; wr_value_i = 64'h1234; rd_a_id_i = 3; rd_b_id_i = 3;
    step();
    wr_en_i = 0;
    chk("byp_a", rd_a_value_o, 64'h1234);
    chk("byp_b", rd_b_value_o, 64'h1234);
    claim_en_i = 1; claim_id_i = 5; rd_a_id_i = 5;
    step();
    claim_en_i = 0;
    chk("claim5_busy", 64'(rd_a_busy_o), 64'd1);
    chk("claim5_val", rd_a_value_o, RV);
    wr_en_i = 1; wr_id_i = 5; wr_value_i = 64'h55;
    step();
    wr_en_i = 0;
    chk("wr5_busy", 64'(rd_a_busy_o), 64'd0);
    chk("wr5_val", rd_a_value_o, 64'h55);
    step();
    chk("wr5_stored", rd_a_value_o, 64'h55);
    claim_en_i = 1; claim_id_i = 7; wr_en_i = 1; wr_id_i = 7; wr_value_i = 64'h77; rd_a_id_i = 7;
    step();
    claim_en_i = 0; wr_en_i = 0;
    chk("cw7_val", rd_a_value_o, 64'h77);
    chk("cw7_busy", 64'(rd_a_busy_o), 64'd1);
    step();
    chk("cw7_stored_val", rd_a_value_o, 64'h77);
    chk("cw7_stored_busy", 64'(rd_a_busy_o), 64'd1);
    claim_en_i = 1; claim_id_i = 2; wr_en_i = 1; wr_id_i = 9; wr_value_i = 64'h99;
    rd_a_id_i = 2; rd_b_id_i = 9;
    step();
    claim_en_i = 0; wr_en_i = 0;
    chk("c2_busy", 64'(rd_a_busy_o), 64'd1);
    chk("w9_busy", 64'(rd_b_busy_o), 64'd0);
    chk("w9_val", rd_b_value_o, 64'h99);
    rd_a_id_i = 3; rd_b_id_i = 4;
    step();
    chk("id3_kept", rd_a_value_o, 64'h1234);
    chk("id4_untouched", rd_b_value_o, RV);
    reset_i = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("hold_ready", 64'(ready_o), 64'd0);
      chk("hold_rd", rd_a_value_o, 64'd0);
    end
    reset_i = 0;
    for (int c = 0; c < 7; c++) step();
    chk("mid_ready", 64'(ready_o), 64'd0);
    reset_i = 1;
    step();
    reset_i = 0;
    rd_a_id_i = 0;
    for (int c = 0; c < 16; c++) begin
      wr_en_i = (c == 14); wr_id_i = 0; wr_value_i = 64'hBAD;
      claim_en_i = (c == 14); claim_id_i = 1;
      chk("restart_ready_low", 64'(ready_o), 64'd0);
      chk("restart_rd_zero", rd_a_value_o, 64'd0);
      step();
    end
    wr_en_i = 0; claim_en_i = 0;
    chk("restart_ready_high", 64'(ready_o), 64'd1);
    rd_a_id_i = 0; rd_b_id_i = 1;
    step();
    chk("init_wr_ignored", rd_a_value_o, RV);
    chk("init_claim_ignored", 64'(rd_b_busy_o), 64'd0);
    rd_a_id_i = 3; rd_b_id_i = 7;
    step();
    chk("id3_reinit", rd_a_value_o, RV);
    chk("id7_busy_cleared", 64'(rd_b_busy_o), 64'd0);
    wr_en_i = 1; wr_id_i = 4; wr_value_i = 64'hDEAD; rd_a_id_i = 4;
    step();
    wr_en_i = 0;
    chk("wr4", rd_a_value_o, 64'hDEAD);
    step();
    chk("wr4_stored", rd_a_value_o, 64'hDEAD);
    reset_i = 1;
    step();
    reset_i = 0;
    sweep("pulse");
    step();
    chk("id4_reinit", rd_a_value_o, RV);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end
endmodule
